ls_exec_unit: RTL

- Load/store execution stage directly downstream of the load/store buffer.
- Accepts one memory op at a time, computes the effective address and drives the memory controller request/response handshake.
- Load results are sign/zero-extended and broadcast to the ROB/RS/LSB.
- Stores are address-resolved and reported to the ROB, held, then written only on the ROB commit pulse.

---
 rtl/ls_exec_unit_pkg.sv | 53 +++++
 rtl/ls_exec_unit_load_extend.sv | 27 ++
 rtl/ls_exec_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ls_exec_unit_pkg.sv
// Shared definitions for the load/store execution unit: op encodings,
// default widths, FSM state encoding, memory access lengths and small
// op-decoding helpers used by the top FSM and the load extender.
package ls_exec_unit_pkg;

  localparam int PKG_ROB_ID_W = 4;
  localparam int PKG_OP_W     = 6;

  // Op encodings shared with the load/store buffer
  localparam logic [PKG_OP_W-1:0] OP_LB  = 6'd0;
  localparam logic [PKG_OP_W-1:0] OP_LH  = 6'd1;
  localparam logic [PKG_OP_W-1:0] OP_LW  = 6'd2;
  localparam logic [PKG_OP_W-1:0] OP_LBU = 6'd3;
  localparam logic [PKG_OP_W-1:0] OP_LHU = 6'd4;
  localparam logic [PKG_OP_W-1:0] OP_SB  = 6'd5;
  localparam logic [PKG_OP_W-1:0] OP_SH  = 6'd6;
  localparam logic [PKG_OP_W-1:0] OP_SW  = 6'd7;

  // Memory controller access lengths in bytes
  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // LD_DRAIN swallows the mc_done of a load flushed after it was acked
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_REQ   = 3'd1,
    LD_WAIT  = 3'd2,
    LD_DRAIN = 3'd3,
    ST_HOLD  = 3'd4,
    ST_REQ   = 3'd5,
    ST_WAIT  = 3'd6
  } state_e;

  function automatic logic [2:0] op_len(input logic [PKG_OP_W-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_len = LEN_B;
      OP_LH, OP_LHU, OP_SH: op_len = LEN_H;
      OP_LW, OP_SW:         op_len = LEN_W;
      default:              op_len = 3'd0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [PKG_OP_W-1:0] op);
    op_is_load = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                 (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [PKG_OP_W-1:0] op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ls_exec_unit_load_extend.sv
// load_extend: combinational sign/zero extension of raw memory read data.
// Ports: op  - load op id (LB/LH/LW/LBU/LHU)
//        raw - read data from the memory controller, low bytes significant
//        value - 32-bit architectural load result
module load_extend
  import ls_exec_unit_pkg::*;
#(
  parameter int OP_W = PKG_OP_W
) (
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     raw,
  output logic [31:0]     value
);

  // Select extension by op; anything that is not a narrow load passes through
  always_comb begin
    value = raw;
    case (op)
      OP_LB:   value = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   value = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  value = {24'd0, raw[7:0]};
      OP_LHU:  value = {16'd0, raw[15:0]};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/ls_exec_unit.sv
// ls_exec_unit: load/store execution stage behind the load/store buffer.
// Accepts one op at a time, computes rs1+imm, runs the memory controller
// req/ack/done handshake, broadcasts load data or store addresses, and
// holds stores until the ROB commits them.
// Ports: clk/rst (sync active-high)/rdy (global freeze); in_* issue port;
//        ready; mc_* memory controller handshake; rob_commit_* store commit;
//        res_* result broadcast; roll_back speculative flush.
module ls_exec_unit
  import ls_exec_unit_pkg::*;
#(
  parameter int ROB_ID_W = PKG_ROB_ID_W,
  parameter int OP_W     = PKG_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                in_valid,
  input  logic [OP_W-1:0]     in_op,
  input  logic [31:0]         in_rs1,
  input  logic [31:0]         in_rs2,
  input  logic [31:0]         in_imm,
  input  logic [ROB_ID_W-1:0] in_rob_id,
  output logic                ready,
  output logic                mc_req,
  output logic                mc_wr,
  output logic [31:0]         mc_addr,
  output logic [2:0]          mc_len,
  output logic [31:0]         mc_wdata,
  input  logic                mc_ack,
  input  logic                mc_done,
  input  logic [31:0]         mc_rdata,
  input  logic                rob_commit_store,
  input  logic [ROB_ID_W-1:0] rob_commit_id,
  output logic                res_valid,
  output logic [ROB_ID_W-1:0] res_rob_id,
  output logic [31:0]         res_value,
  output logic                res_is_store,
  input  logic                roll_back
);

  state_e              state_r, next_state_s;
  logic [OP_W-1:0]     op_r;
  logic [ROB_ID_W-1:0] rob_id_r;
  logic                mc_req_r, mc_wr_r, res_valid_r, res_is_store_r;
  logic [31:0]         mc_addr_r, mc_wdata_r, res_value_r;
  logic [2:0]          mc_len_r;
  logic [ROB_ID_W-1:0] res_rob_id_r;
  logic [31:0]         addr_s, ext_s;
  logic                accept_s, ld_accept_s, st_accept_s, load_done_s;

  load_extend #(.OP_W(OP_W)) u_load_extend (
    .op    (op_r),
    .raw   (mc_rdata),
    .value (ext_s)
  );

  // roll_back masks both ready and acceptance, so it wins over in_valid
  assign ready       = (state_r == IDLE) && !roll_back;
  assign addr_s      = in_rs1 + in_imm;
  assign accept_s    = in_valid && ready;
  assign ld_accept_s = accept_s && op_is_load(in_op);
  assign st_accept_s = accept_s && op_is_store(in_op);
  // A flushed load still consumes its mc_done but never broadcasts
  assign load_done_s = (state_r == LD_WAIT) && mc_done && !roll_back;

  // Next-state logic for the single-op load/store sequencer
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ld_accept_s)      next_state_s = LD_REQ;
        else if (st_accept_s) next_state_s = ST_HOLD;
        else                  next_state_s = IDLE;
      end
      LD_REQ: begin
        // An ack coinciding with a flush means the access is in flight
        if (roll_back)   next_state_s = mc_ack ? LD_DRAIN : IDLE;
        else if (mc_ack) next_state_s = LD_WAIT;
        else             next_state_s = LD_REQ;
      end
      LD_WAIT: begin
        if (mc_done)        next_state_s = IDLE;
        else if (roll_back) next_state_s = LD_DRAIN;
        else                next_state_s = LD_WAIT;
      end
      LD_DRAIN: begin
        if (mc_done) next_state_s = IDLE;
        else         next_state_s = LD_DRAIN;
      end
      ST_HOLD: begin
        if (roll_back)
          next_state_s = IDLE;
        else if (rob_commit_store && (rob_commit_id == rob_id_r))
          next_state_s = ST_REQ;
        else
          next_state_s = ST_HOLD;
      end
      // Committed stores ignore roll_back and always finish
      ST_REQ: begin
        if (mc_ack) next_state_s = ST_WAIT;
        else        next_state_s = ST_REQ;
      end
      ST_WAIT: begin
        if (mc_done) next_state_s = IDLE;
        else         next_state_s = ST_WAIT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, captured op context and registered outputs; rdy=0 freezes all
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      op_r           <= '0;
      rob_id_r       <= '0;
      mc_req_r       <= 1'b0;
      mc_wr_r        <= 1'b0;
      mc_addr_r      <= 32'd0;
      mc_len_r       <= 3'd0;
      mc_wdata_r     <= 32'd0;
      res_valid_r    <= 1'b0;
      res_is_store_r <= 1'b0;
      res_rob_id_r   <= '0;
      res_value_r    <= 32'd0;
    end else if (rdy) begin
      state_r  <= next_state_s;
      mc_req_r <= (next_state_s == LD_REQ) || (next_state_s == ST_REQ);
      mc_wr_r  <= (next_state_s == ST_REQ);
      if (accept_s) begin
        op_r       <= in_op;
        rob_id_r   <= in_rob_id;
        mc_addr_r  <= addr_s;
        mc_len_r   <= op_len(in_op);
        mc_wdata_r <= st_accept_s ? in_rs2 : 32'd0;
      end
      res_valid_r    <= st_accept_s || load_done_s;
      res_is_store_r <= st_accept_s;
      if (st_accept_s) begin
        res_rob_id_r <= in_rob_id;
        res_value_r  <= addr_s;
      end else if (load_done_s) begin
        res_rob_id_r <= rob_id_r;
        res_value_r  <= ext_s;
      end
    end
  end

  assign mc_req       = mc_req_r;
  assign mc_wr        = mc_wr_r;
  assign mc_addr      = mc_addr_r;
  assign mc_len       = mc_len_r;
  assign mc_wdata     = mc_wdata_r;
  assign res_valid    = res_valid_r;
  assign res_is_store = res_is_store_r;
  assign res_rob_id   = res_rob_id_r;
  assign res_value    = res_value_r;

endmodule
